// File: rtl/shift_input_conditioner_amisha_pkg.sv
// Shared debounce constants and group FSM encoding for the shifter board build.
// Defaults give a 20 ms acceptance window at 50 MHz.
package shift_input_conditioner_amisha_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } db_state_t;

    localparam int DB_COUNT_DEF = 1000000;
    localparam int CNT_W_DEF    = 20;

endpackage

// File: rtl/shift_input_conditioner_amisha_db_group.sv
// One debounce group: 2-FF sync, candidate/counter FSM, registered stable word.
// Accepts a clean change DB_COUNT+3 edges after the raw edge; no backpressure, upd is a combinational one-cycle flag.
module db_group_amisha
    import shift_input_conditioner_amisha_pkg::*;
#(
    parameter int W        = 1,
    parameter int DB_COUNT = DB_COUNT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable,
    output logic         upd
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    logic [W-1:0]     sync1;
    logic [W-1:0]     sync2;
    logic [W-1:0]     cand;
    logic [W-1:0]     cand_nxt;
    logic [W-1:0]     stable_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    db_state_t        state;
    db_state_t        state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
            state  <= IDLE;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            cand   <= cand_nxt;
            cnt    <= cnt_nxt;
            stable <= stable_nxt;
            state  <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        upd        = 1'b0;
        case (state)
            IDLE: begin
                if (sync2 != stable) begin
                    cand_nxt  = sync2;
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Returning to the accepted value abandons the count silently.
                if (sync2 == stable) begin
                    state_nxt = IDLE;
                end else if (sync2 != cand) begin
                    cand_nxt = sync2;
                    cnt_nxt  = '0;
                end else if (cnt == CNT_LAST) begin
                    stable_nxt = cand;
                    upd        = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/shift_input_conditioner_amisha.sv
// Debounces pushbuttons (amt) and switches (data) for the shifter; upd pulses when either accepted word changes.
// Output follows a clean raw change by DB_COUNT+3 edges; no backpressure. SHIFT_COND_UPD_CNT_EN adds upd_cnt_amisha.
module shift_input_conditioner_amisha
    import shift_input_conditioner_amisha_pkg::*;
#(
    parameter int N_AMT    = 3,
    parameter int N_DATA   = 8,
    parameter int DB_COUNT = DB_COUNT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk_amisha,
    input  logic              reset_amisha,
    input  logic [N_AMT-1:0]  btn_amisha,
    input  logic [N_DATA-1:0] sw_amisha,
    output logic [N_AMT-1:0]  amt_amisha,
    output logic [N_DATA-1:0] a_amisha,
`ifdef SHIFT_COND_UPD_CNT_EN
    output logic [7:0]        upd_cnt_amisha,
`endif
    output logic              upd_amisha
);

    logic btn_upd;
    logic sw_upd;

    db_group_amisha #(.W(N_AMT), .DB_COUNT(DB_COUNT), .CNT_W(CNT_W)) u_btn_db (
        .clk    (clk_amisha),
        .rst    (reset_amisha),
        .raw    (btn_amisha),
        .stable (amt_amisha),
        .upd    (btn_upd)
    );

    db_group_amisha #(.W(N_DATA), .DB_COUNT(DB_COUNT), .CNT_W(CNT_W)) u_sw_db (
        .clk    (clk_amisha),
        .rst    (reset_amisha),
        .raw    (sw_amisha),
        .stable (a_amisha),
        .upd    (sw_upd)
    );

    // Registered so the pulse lines up with the cycle the new stable words appear.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) upd_amisha <= 1'b0;
        else              upd_amisha <= btn_upd | sw_upd;
    end

`ifdef SHIFT_COND_UPD_CNT_EN
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha)    upd_cnt_amisha <= '0;
        else if (upd_amisha) upd_cnt_amisha <= upd_cnt_amisha + 8'd1;
    end
`endif

endmodule

// File: tb/tb_shift_input_conditioner_amisha.sv
// Scoreboard bench for shift_input_conditioner_amisha with DB_COUNT=4, CNT_W=3.
module tb_shift_input_conditioner_amisha;

    localparam int LAT = 7;  // DB_COUNT + 3

    typedef struct {
        int         cyc;
        logic [2:0] amt;
        logic [7:0] a;
    } exp_t;

    logic       clk_amisha = 1'b0;
    logic       reset_amisha;
    logic [2:0] btn_amisha;
    logic [7:0] sw_amisha;
    logic [2:0] amt_amisha;
    logic [7:0] a_amisha;
    logic       upd_amisha;
`ifdef SHIFT_COND_UPD_CNT_EN
    logic [7:0] upd_cnt_amisha;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [2:0] exp_amt;
    logic [7:0] exp_a;

    shift_input_conditioner_amisha #(
        .N_AMT(3), .N_DATA(8), .DB_COUNT(4), .CNT_W(3)
    ) dut (
        .clk_amisha     (clk_amisha),
        .reset_amisha   (reset_amisha),
        .btn_amisha     (btn_amisha),
        .sw_amisha      (sw_amisha),
        .amt_amisha     (amt_amisha),
        .a_amisha       (a_amisha),
`ifdef SHIFT_COND_UPD_CNT_EN
        .upd_cnt_amisha (upd_cnt_amisha),
`endif
        .upd_amisha     (upd_amisha)
    );

    always #5 clk_amisha = ~clk_amisha;
    always @(posedge clk_amisha) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Record an acceptance expected LAT edges after the change made in this cycle.
    task automatic push_accept();
        exp_t e;
        e.cyc = cyc + LAT;
        e.amt = exp_amt;
        e.a   = exp_a;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_amisha);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk_amisha);
        wait_cyc(4);
        check(name, sb.size(), 0);
    endtask

    // Monitor: every upd pulse must match the oldest pending acceptance.
    always @(negedge clk_amisha) begin
        if (!reset_amisha && upd_amisha) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_upd: got upd=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_cycle", cyc, e.cyc);
                check("upd_amt", int'(amt_amisha), int'(e.amt));
                check("upd_a", int'(a_amisha), int'(e.a));
            end
        end
    end

    initial begin
        reset_amisha = 1'b1;
        btn_amisha   = 3'b101;
        sw_amisha    = 8'hA5;
        exp_amt      = '0;
        exp_a        = '0;

        // Reset holds outputs low even with inputs applied.
        wait_cyc(3);
        check("reset_amt", int'(amt_amisha), 0);
        check("reset_a", int'(a_amisha), 0);
        check("reset_upd", int'(upd_amisha), 0);
        reset_amisha = 1'b0;
        exp_amt = 3'b101;
        exp_a   = 8'hA5;
        push_accept();  // both groups accept together: one pulse
        drain("drain_after_reset");
        check("post_reset_amt", int'(amt_amisha), 5);
        check("post_reset_a", int'(a_amisha), 'hA5);

        // Clean single change on the switches.
        sw_amisha = 8'h00; exp_a = 8'h00; push_accept();
        drain("drain_sw_zero");
        sw_amisha = 8'h3C; exp_a = 8'h3C; push_accept();
        drain("drain_sw_3c");
        check("clean_a", int'(a_amisha), 'h3C);
        check("clean_amt_unchanged", int'(amt_amisha), 5);

        // Bouncing buttons only accept once settled.
        btn_amisha = 3'b000; exp_amt = 3'b000; push_accept();
        drain("drain_btn_zero");
        for (int i = 0; i < 10; i++) begin
            btn_amisha = (i % 2 == 0) ? 3'b010 : 3'b000;
            wait_cyc(2);
        end
        btn_amisha = 3'b010; exp_amt = 3'b010; push_accept();
        drain("drain_bounce");
        check("bounce_amt", int'(amt_amisha), 2);

        // Bounce-back to the accepted value produces nothing.
        sw_amisha = 8'h00; exp_a = 8'h00; push_accept();
        drain("drain_sw_back_zero");
        sw_amisha = 8'hFF;
        wait_cyc(3);
        sw_amisha = 8'h00;
        wait_cyc(15);
        check("bounce_back_a", int'(a_amisha), 0);
        check("bounce_back_queue", sb.size(), 0);

        // Reset in the middle of a count.
        btn_amisha = 3'b111;
        wait_cyc(3);
        reset_amisha = 1'b1;
        #1;
        check("midreset_amt", int'(amt_amisha), 0);
        check("midreset_a", int'(a_amisha), 0);
        check("midreset_upd", int'(upd_amisha), 0);
        exp_amt = '0;
        exp_a   = '0;
        wait_cyc(2);
        reset_amisha = 1'b0;
        exp_amt = 3'b111; push_accept();
        drain("drain_midreset");
        check("midreset_release_amt", int'(amt_amisha), 7);

`ifdef SHIFT_COND_UPD_CNT_EN
        reset_amisha = 1'b1;
        btn_amisha   = 3'b000;
        sw_amisha    = 8'h00;
        wait_cyc(2);
        check("cnt_reset", int'(upd_cnt_amisha), 0);
        reset_amisha = 1'b0;
        exp_amt = '0;
        exp_a   = '0;
        wait_cyc(5);
        for (int i = 0; i < 300; i++) begin
            sw_amisha = (i % 2 == 0) ? 8'h01 : 8'h02;
            exp_a = sw_amisha;
            push_accept();
            wait_cyc(9);
        end
        drain("drain_cnt");
        check("upd_cnt_wrap", int'(upd_cnt_amisha), 44);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
